// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter load controller.
//   PC_DW      byte width of each counter half and of the data bus
//   pc_state_t run/halt/step mode of the counters
//   *_RST      reset values for the registered control outputs
package pc_pkg;

  localparam int PC_DW = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } pc_state_t;

  localparam pc_state_t STATE_RST = HALTED;
  localparam logic      PE_RST    = 1'b1;
  localparam logic      JT_RST    = 1'b0;
  localparam logic      ERR_RST   = 1'b0;
  localparam logic      SV_RST    = 1'b0;

endpackage

// File: rtl/pc_hitmp_reg.sv
// pc_hitmp_reg: staged high-byte jump target plus its valid flag.
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   we_n_i   active-low write; stages d_i and sets valid
//   clr_i    clears valid (a write on the same edge takes priority)
//   d_i      byte to stage
//   data_o   staged byte
//   valid_o  staged byte present
module pc_hitmp_reg
  import pc_pkg::*;
#(
  parameter int DW = PC_DW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_n_i,
  input  logic          clr_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= SV_RST;
    end else if (!we_n_i) begin
      data_q  <= d_i;
      valid_q <= 1'b1;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_load_ctrl.sv
// pc_load_ctrl: load/count control for the chained 8-bit program counter.
//   CP, _MR        clock (rising) and asynchronous active-low reset
//   D              target byte bus
//   _hitmp_we      active-low: stage D as high-byte target
//   _jmp, _jmpc    active-low jump requests (unconditional / gated by cond)
//   cond, near     jump condition; near selects pc_hi as the high byte
//   pc_hi          current high counter value
//   halt_req       level halt request
//   step_req       single-step request while halted
//   _PE            registered active-low parallel enable to both counters
//   Dlo, Dhi       load values, held between loads
//   CEP            count enable to both counters
//   stage_valid    staged high byte present
//   jump_taken     one-cycle pulse coincident with _PE low
//   err            sticky: far jump requested with nothing staged
//
// state  | meaning
// RUN    | counters increment every cycle except the load cycle
// HALTED | counters frozen; jumps still load (debug load)
// STEP   | one increment cycle, then back to HALTED
module pc_load_ctrl
  import pc_pkg::*;
#(
  parameter int DW                  = PC_DW,
  parameter bit CLEAR_STAGE_ON_JUMP = 1'b1
) (
  input  logic          CP,
  input  logic          _MR,
  input  logic [DW-1:0] D,
  input  logic          _hitmp_we,
  input  logic          _jmp,
  input  logic          _jmpc,
  input  logic          cond,
  input  logic          near,
  input  logic [DW-1:0] pc_hi,
  input  logic          halt_req,
  input  logic          step_req,
  output logic          _PE,
  output logic [DW-1:0] Dlo,
  output logic [DW-1:0] Dhi,
  output logic          CEP,
  output logic          stage_valid,
  output logic          jump_taken,
  output logic          err
);

  pc_state_t     state_q, state_d;
  logic          pe_q, pe_d;
  logic          jt_q, jt_d;
  logic          err_q, err_d;
  logic          step_q;
  logic [DW-1:0] dlo_q, dlo_d;
  logic [DW-1:0] dhi_q, dhi_d;
  logic [DW-1:0] stage_data;
  logic          stage_vld;
  logic          jmp_req, accept, stage_clr, step_edge;

  pc_hitmp_reg #(.DW(DW)) u_hitmp (
    .clk_i   (CP),
    .rst_n_i (_MR),
    .we_n_i  (_hitmp_we),
    .clr_i   (stage_clr),
    .d_i     (D),
    .data_o  (stage_data),
    .valid_o (stage_vld)
  );

  // Both requests low collapses to the unconditional case automatically.
  assign jmp_req   = !_jmp || (!_jmpc && cond);
  assign accept    = jmp_req && (near || stage_vld);
  assign stage_clr = CLEAR_STAGE_ON_JUMP && accept && !near;
  // A held step_req yields only one step per HALTED entry.
  assign step_edge = step_req && !step_q;

  always_comb begin
    pe_d  = !accept;
    jt_d  = accept;
    err_d = err_q || (jmp_req && !near && !stage_vld);
    dlo_d = dlo_q;
    dhi_d = dhi_q;
    if (accept) begin
      dlo_d = D;
      // Old staged value is used even when a new byte is staged this edge.
      dhi_d = near ? pc_hi : stage_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: begin
        if (!halt_req)      state_d = RUN;
        else if (step_edge) state_d = STEP;
      end
      RUN:     if (halt_req) state_d = HALTED;
      STEP:    state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge CP or negedge _MR) begin
    if (!_MR) begin
      state_q <= STATE_RST;
      pe_q    <= PE_RST;
      jt_q    <= JT_RST;
      err_q   <= ERR_RST;
      step_q  <= 1'b0;
      dlo_q   <= '0;
      dhi_q   <= '0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      jt_q    <= jt_d;
      err_q   <= err_d;
      step_q  <= step_req;
      dlo_q   <= dlo_d;
      dhi_q   <= dhi_d;
    end
  end

  assign _PE         = pe_q;
  assign jump_taken  = jt_q;
  assign err         = err_q;
  assign Dlo         = dlo_q;
  assign Dhi         = dhi_q;
  assign stage_valid = stage_vld;
  assign CEP         = (state_q == RUN || state_q == STEP) && pe_q;

endmodule

// File: tb/tb_pc_load_ctrl.sv
module tb_pc_load_ctrl;

  localparam bit CLR = 1'b1;

  logic       CP = 1'b0;
  logic       mr_n;
  logic [7:0] D;
  logic       hit_n, jmp_n, jmpc_n, cond, near;
  logic [7:0] pc_hi;
  logic       halt_req, step_req;
  logic       pe_n, cep, sv, jt, err;
  logic [7:0] dlo, dhi;

  pc_load_ctrl #(.DW(8), .CLEAR_STAGE_ON_JUMP(CLR)) dut (
    .CP(CP), ._MR(mr_n), .D(D), ._hitmp_we(hit_n), ._jmp(jmp_n), ._jmpc(jmpc_n),
    .cond(cond), .near(near), .pc_hi(pc_hi), .halt_req(halt_req), .step_req(step_req),
    ._PE(pe_n), .Dlo(dlo), .Dhi(dhi), .CEP(cep), .stage_valid(sv),
    .jump_taken(jt), .err(err)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic       pe;
    logic [7:0] dlo;
    logic [7:0] dhi;
    logic       cep;
    logic       sv;
    logic       jt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode as a name, plus the visible state the rules talk about.
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
  int         m_mode;
  logic [7:0] m_stage, m_dlo, m_dhi;
  bit         m_sv, m_err, m_step_prev;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    m_mode = M_HALT; m_stage = 8'h00; m_dlo = 8'h00; m_dhi = 8'h00;
    m_sv = 0; m_err = 0; m_step_prev = 0;
  endtask

  task automatic idle();
    D = 8'h00; hit_n = 1; jmp_n = 1; jmpc_n = 1; cond = 0; near = 0; pc_hi = 8'h00;
    step_req = 0;
  endtask

  // One clock edge: apply the rules to the inputs present at the edge, queue the result.
  task automatic tick();
    bit   req, acc, step_edge;
    exp_t e;
    @(posedge CP);
    req = !jmp_n || (!jmpc_n && cond);
    acc = req && (near || m_sv);
    if (req && !acc) m_err = 1;
    if (acc) begin
      m_dlo = D;
      m_dhi = near ? pc_hi : m_stage;
    end
    if (!hit_n) begin
      m_stage = D; m_sv = 1;
    end else if (acc && !near && CLR) begin
      m_sv = 0;
    end
    step_edge = step_req && !m_step_prev;
    m_step_prev = step_req;
    case (m_mode)
      M_HALT: if (!halt_req) m_mode = M_RUN; else if (step_edge) m_mode = M_STEP;
      M_RUN:  if (halt_req) m_mode = M_HALT;
      default: m_mode = M_HALT;
    endcase
    e.pe = !acc; e.jt = acc; e.dlo = m_dlo; e.dhi = m_dhi;
    e.cep = (m_mode != M_HALT) && !acc;
    e.sv = m_sv; e.err = m_err;
    exp_q.push_back(e);
    #1;
  endtask

  // Drains the scoreboard, then asserts reset between edges and checks it took effect at once.
  task automatic reset_pulse();
    @(negedge CP); #1;
    idle();
    mr_n = 0;
    #1;
    chk("rst_pe", pe_n, 1); chk("rst_jt", jt, 0); chk("rst_sv", sv, 0);
    chk("rst_cep", cep, 0); chk("rst_err", err, 0);
    chk("rst_dlo", dlo, 0); chk("rst_dhi", dhi, 0);
    model_reset();
    @(negedge CP); #1;
    mr_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CP);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pe_n", pe_n, e.pe);
        chk("jump_taken", jt, e.jt);
        chk("cep", cep, e.cep);
        chk("stage_valid", sv, e.sv);
        chk("err", err, e.err);
        if (!e.pe) begin
          chk("dlo", dlo, e.dlo);
          chk("dhi", dhi, e.dhi);
        end else begin
          chk("dlo_hold", dlo, e.dlo);
          chk("dhi_hold", dhi, e.dhi);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    mr_n = 0; halt_req = 0; idle();
    model_reset();
    reset_pulse();

    // Start-up, far jump with staging, conditional jumps.
    tick();
    D = 8'h12; hit_n = 0; tick();
    idle(); D = 8'h34; jmp_n = 0; near = 0; tick();
    idle(); tick();
    D = 8'h56; jmpc_n = 0; cond = 0; tick();
    D = 8'h56; jmpc_n = 0; cond = 1; near = 1; pc_hi = 8'hA0; tick();
    idle(); tick();
    // Stage and jump on the same edge: old value used, new one stays valid.
    D = 8'h77; hit_n = 0; tick();
    D = 8'h88; hit_n = 0; jmp_n = 0; tick();
    idle(); D = 8'h99; jmp_n = 0; tick();
    D = 8'h9A; jmp_n = 0; jmpc_n = 0; near = 1; pc_hi = 8'h3C; tick();
    idle(); tick();

    // Far jump with nothing staged: dropped, err sticky.
    reset_pulse();
    D = 8'h21; jmp_n = 0; tick();
    idle(); tick(); tick();

    // Halt, single step, held step.
    halt_req = 1; tick(); tick();
    step_req = 1; tick();
    step_req = 0; tick(); tick();
    step_req = 1; tick(); tick(); tick();
    step_req = 0; tick();
    D = 8'h5E; jmp_n = 0; near = 1; pc_hi = 8'h11; tick();
    idle(); tick();
    step_req = 1; tick();
    halt_req = 0; step_req = 1; tick(); tick();
    idle(); tick();

    // Randomized traffic.
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      D        = 8'($urandom);
      pc_hi    = 8'($urandom);
      hit_n    = ($urandom_range(0, 3) != 0);
      jmp_n    = ($urandom_range(0, 5) != 0);
      jmpc_n   = ($urandom_range(0, 4) != 0);
      cond     = 1'($urandom);
      near     = ($urandom_range(0, 2) == 0);
      step_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      tick();
      if (i == 200) begin
        reset_pulse();
      end
    end

    // Reset during the load cycle.
    reset_pulse();
    tick();
    D = 8'h42; hit_n = 0; tick();
    idle(); D = 8'h43; jmp_n = 0; tick();
    idle();
    chk("midjump_pe_low", pe_n, 0);
    reset_pulse();
    tick(); tick();

    @(negedge CP); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
